// File: rtl/commit_unit.sv
// commit_unit: applies ROB commits to the register file, fetch redirect and a store buffer.
// Optional COMMIT_INSTRET_EN adds a 64-bit retired-instruction counter on instret_o.
module commit_unit #(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        commit_valid_i,
  input  logic [31:0] commit_pc_i,
  input  logic [31:0] commit_instr_i,
  input  logic [4:0]  commit_rd_addr_i,
  input  logic [31:0] commit_result_i,
  input  logic        commit_write_enable_i,
  input  logic        commit_store_to_mem_i,
  input  logic [31:0] commit_new_pc_i,
  input  logic        commit_branch_taken_i,
  output logic        commit_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  output logic        sb_empty_o,
  output logic        misaligned_o,
  output logic [63:0] instret_o
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  state_e     state_q;
  state_e     state_d;
  sb_entry_t  sb_q [SB_DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  logic       mis_q;

  logic [2:0]  funct3;
  logic [1:0]  lo;
  logic [31:0] sdata;
  logic        is_sb;
  logic        is_sh;
  sb_entry_t   st_entry;
  sb_entry_t   head_entry;
  logic        st_mis;
  logic        st_commit;
  logic        push;
  logic        pop;

  logic unused_bits;
  assign unused_bits = ^{commit_pc_i,
                         commit_instr_i[31:15],
                         commit_instr_i[11:0]};

  assign funct3 = commit_instr_i[14:12];
  assign lo     = commit_result_i[1:0];
  assign sdata  = commit_new_pc_i;
  assign is_sb  = (funct3 == 3'b000);
  assign is_sh  = (funct3 == 3'b001);

  // Register-file write and fetch redirect straight off the commit bus
  always_comb begin
    rf_we_o          = commit_valid_i
                     & commit_write_enable_i
                     & (commit_rd_addr_i != 5'd0);
    rf_waddr_o       = commit_valid_i ? commit_rd_addr_i : 5'd0;
    rf_wdata_o       = commit_valid_i ? commit_result_i : 32'd0;
    redirect_valid_o = commit_valid_i & commit_branch_taken_i;
    redirect_pc_o    = redirect_valid_o ? commit_new_pc_i : 32'd0;
  end

  // Lane-align store data, build byte enables, flag misalignment
  always_comb begin
    st_entry      = '0;
    st_mis        = 1'b0;
    st_entry.addr = {commit_result_i[31:2], 2'b00};
    unique case (1'b1)
      is_sb: begin
        st_entry.be    = 4'b0001 << lo;
        st_entry.wdata = {4{sdata[7:0]}};
      end
      is_sh: begin
        st_entry.be    = 4'b0011 << {lo[1], 1'b0};
        st_entry.wdata = {2{sdata[15:0]}};
        st_mis         = lo[0];
      end
      default: begin
        st_entry.be    = 4'hF;
        st_entry.wdata = sdata;
        st_mis         = (lo != 2'b00);
      end
    endcase
  end

  assign commit_ready_o = (count_q < DEPTH_C);
  assign st_commit      = commit_valid_i & commit_store_to_mem_i;
  assign push           = st_commit & ~st_mis & commit_ready_o;
  assign pop            = (state_q == S_REQ) & dmem_gnt_i;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_n = count_q;
    if (push && !pop) begin
      count_n = count_q + 1'b1;
    end else if (!push && pop) begin
      count_n = count_q - 1'b1;
    end
  end

  // Store buffer storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      if (push) begin
        sb_q[tail_q] <= st_entry;
        tail_q       <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_n;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM: request whenever the buffer will hold a store
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_n != '0) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (count_n == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign head_entry   = sb_q[head_q];
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_addr_o  = dmem_req_o ? head_entry.addr : 32'd0;
  assign dmem_wdata_o = dmem_req_o ? head_entry.wdata : 32'd0;
  assign dmem_be_o    = dmem_req_o ? head_entry.be : 4'd0;
  assign sb_empty_o   = (count_q == '0) & (state_q == S_IDLE);

  // One-cycle pulse for a dropped misaligned store
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= st_commit & st_mis;
    end
  end

  assign misaligned_o = mis_q;

`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instret_q <= 64'd0;
    end else if (commit_valid_i) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 64'd0;
`endif

  store_needs_room: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    !(commit_valid_i && commit_store_to_mem_i && !commit_ready_o)
  );

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed and random commits checked against a queue-based model.
// Expected instret follows COMMIT_INSTRET_EN.
module tb_commit_unit;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        commit_valid_i;
  logic [31:0] commit_pc_i;
  logic [31:0] commit_instr_i;
  logic [4:0]  commit_rd_addr_i;
  logic [31:0] commit_result_i;
  logic        commit_write_enable_i;
  logic        commit_store_to_mem_i;
  logic [31:0] commit_new_pc_i;
  logic        commit_branch_taken_i;
  logic        commit_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        sb_empty_o;
  logic        misaligned_o;
  logic [63:0] instret_o;

  commit_unit #(.SB_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .commit_valid_i(commit_valid_i),
    .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i),
    .commit_rd_addr_i(commit_rd_addr_i),
    .commit_result_i(commit_result_i),
    .commit_write_enable_i(commit_write_enable_i),
    .commit_store_to_mem_i(commit_store_to_mem_i),
    .commit_new_pc_i(commit_new_pc_i),
    .commit_branch_taken_i(commit_branch_taken_i),
    .commit_ready_o(commit_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o),
    .dmem_be_o(dmem_be_o),
    .sb_empty_o(sb_empty_o),
    .misaligned_o(misaligned_o),
    .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t         sbq[$];
  bit          mis_pend;
  logic [63:0] icount;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void fmt(input logic [31:0] addr,
                              input logic [31:0] data,
                              input logic [2:0] f3,
                              output st_t e, output bit mis);
    int unsigned a;
    a = addr & 32'd3;
    e.addr = addr - a;
    if (f3 == 3'd0) begin
      e.be = 4'(1 << a);
      e.data = (data & 32'hFF) * 32'h01010101;
      mis = 0;
    end else if (f3 == 3'd1) begin
      e.be = 4'(3 << ((a / 2) * 2));
      e.data = (data & 32'hFFFF) * 32'h00010001;
      mis = (a % 2) == 1;
    end else begin
      e.be = 4'hF;
      e.data = data;
      mis = a != 0;
    end
  endfunction

  function automatic logic [63:0] exp_instret();
`ifdef COMMIT_INSTRET_EN
    return icount;
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    sbq.delete();
    mis_pend = 0;
    icount = 64'd0;
  endtask

  task automatic idle();
    commit_valid_i = 0;
    commit_pc_i = 0;
    commit_instr_i = 0;
    commit_rd_addr_i = 0;
    commit_result_i = 0;
    commit_write_enable_i = 0;
    commit_store_to_mem_i = 0;
    commit_new_pc_i = 0;
    commit_branch_taken_i = 0;
  endtask

  task automatic commit(input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] res, input logic we,
                        input logic st, input logic [31:0] npc,
                        input logic tk);
    logic [31:0] ins;
    ins = $urandom;
    ins[14:12] = f3;
    commit_valid_i = 1;
    commit_pc_i = $urandom;
    commit_instr_i = ins;
    commit_rd_addr_i = rd;
    commit_result_i = res;
    commit_write_enable_i = we;
    commit_store_to_mem_i = st;
    commit_new_pc_i = npc;
    commit_branch_taken_i = tk;
  endtask

  // Check every output against the model, then advance one clock.
  task automatic tick();
    bit rdy;
    bit mis;
    st_t e;
    #2;
    rdy = sbq.size() < DEPTH;
    check_eq("rf_we", rf_we_o, commit_valid_i
             && commit_write_enable_i && commit_rd_addr_i != 0);
    if (commit_valid_i) begin
      check_eq("rf_waddr", rf_waddr_o, commit_rd_addr_i);
      check_eq("rf_wdata", rf_wdata_o, commit_result_i);
    end
    check_eq("redir_v", redirect_valid_o,
             commit_valid_i && commit_branch_taken_i);
    if (commit_valid_i && commit_branch_taken_i)
      check_eq("redir_pc", redirect_pc_o, commit_new_pc_i);
    check_eq("ready", commit_ready_o, rdy);
    check_eq("req", dmem_req_o, sbq.size() != 0);
    if (sbq.size() != 0) begin
      check_eq("addr", dmem_addr_o, sbq[0].addr);
      check_eq("wdata", dmem_wdata_o, sbq[0].data);
      check_eq("be", dmem_be_o, sbq[0].be);
    end
    check_eq("sb_empty", sb_empty_o, sbq.size() == 0);
    check_eq("misalign", misaligned_o, mis_pend);
    check_eq("instret", instret_o, exp_instret());
    @(posedge clk_i);
    fmt(commit_result_i, commit_new_pc_i,
        commit_instr_i[14:12], e, mis);
    if (sbq.size() != 0 && dmem_gnt_i) void'(sbq.pop_front());
    if (commit_valid_i && commit_store_to_mem_i && !mis && rdy)
      sbq.push_back(e);
    mis_pend = commit_valid_i && commit_store_to_mem_i && mis;
    if (commit_valid_i) icount = icount + 64'd1;
    #1;
  endtask

  initial begin
    idle();
    dmem_gnt_i = 0;
    rstn_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req", dmem_req_o, 0);
    check_eq("rst_ready", commit_ready_o, 1);
    check_eq("rst_empty", sb_empty_o, 1);
    check_eq("rst_mis", misaligned_o, 0);
    check_eq("rst_instret", instret_o, 0);
    check_eq("rst_rf_we", rf_we_o, 0);
    check_eq("rst_redir", redirect_valid_o, 0);
    check_eq("rst_addr", dmem_addr_o, 0);
    rstn_i = 1;

    commit(3'd0, 5'd5, 32'h1234, 1, 0, 0, 0);
    #1;
    check_eq("addi_we", rf_we_o, 1);
    check_eq("addi_wa", rf_waddr_o, 5);
    check_eq("addi_wd", rf_wdata_o, 32'h1234);
    tick();
    commit(3'd0, 5'd0, 32'h1234, 1, 0, 0, 0);
    #1;
    check_eq("x0_we", rf_we_o, 0);
    tick();

    commit(3'd0, 5'd0, 0, 0, 0, 32'h80, 1);
    #1;
    check_eq("br_v", redirect_valid_o, 1);
    check_eq("br_pc", redirect_pc_o, 32'h80);
    tick();
    idle();
    #1;
    check_eq("br_once", redirect_valid_o, 0);
    tick();

    dmem_gnt_i = 1;
    commit(3'd0, 5'd0, 32'h1003, 0, 1, 32'hAB, 0);
    tick();
    idle();
    check_eq("sb_req", dmem_req_o, 1);
    check_eq("sb_addr", dmem_addr_o, 32'h1000);
    check_eq("sb_be", dmem_be_o, 4'b1000);
    check_eq("sb_wdata", dmem_wdata_o, 32'hABABABAB);
    tick();
    check_eq("sb_empty_after", sb_empty_o, 1);

    dmem_gnt_i = 0;
    for (int i = 0; i < 4; i++) begin
      commit(3'd2, 5'd0, 32'h3000 + 4 * i, 0, 1,
             32'h11110000 + i, 0);
      tick();
    end
    idle();
    check_eq("full_ready", commit_ready_o, 0);
    dmem_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_req", dmem_req_o, 1);
      check_eq("drain_addr", dmem_addr_o, 32'h3000 + 4 * i);
      tick();
      if (i == 0) check_eq("ready_pop", commit_ready_o, 1);
    end
    check_eq("drain_empty", sb_empty_o, 1);

    commit(3'd2, 5'd0, 32'h2002, 0, 1, 32'hDEAD, 0);
    tick();
    idle();
    check_eq("mis_pulse", misaligned_o, 1);
    check_eq("mis_empty", sb_empty_o, 1);
    tick();
    check_eq("mis_once", misaligned_o, 0);

    for (int i = 0; i < 2000; i++) begin
      int kind;
      if (((i / 150) % 3) == 1) dmem_gnt_i = 0;
      else dmem_gnt_i = ($urandom % 3) != 0;
      kind = $urandom % 4;
      if (sbq.size() < DEPTH && ($urandom % 4) != 0) begin
        if (kind == 0)
          commit(3'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 0, $urandom, 0);
        else if (kind == 1)
          commit(3'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 0, $urandom, 1'($urandom));
        else
          commit(3'($urandom), 5'($urandom), $urandom,
                 0, 1, $urandom, 0);
      end else begin
        idle();
      end
      tick();
    end

    dmem_gnt_i = 0;
    idle();
    while (sbq.size() != 0) begin
      dmem_gnt_i = 1;
      tick();
      if (n_checks > 200000) break;
    end
    dmem_gnt_i = 0;
    commit(3'd2, 5'd0, 32'h4000, 0, 1, 32'h1, 0);
    tick();
    commit(3'd2, 5'd0, 32'h4004, 0, 1, 32'h2, 0);
    tick();
    idle();
    check_eq("pre_rst_req", dmem_req_o, 1);
    rstn_i = 0;
    #1;
    check_eq("mid_rst_req", dmem_req_o, 0);
    check_eq("mid_rst_empty", sb_empty_o, 1);
    check_eq("mid_rst_instret", instret_o, 0);
    check_eq("mid_rst_ready", commit_ready_o, 1);
    model_reset();
    @(posedge clk_i);
    #1;
    rstn_i = 1;
    dmem_gnt_i = 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

Retire-side consumer of the reorder buffer's commit bus. It applies each in-order committed instruction to architectural state:
- register-file write;
- fetch redirect on taken branch;
- enqueue of committed stores into a small store buffer that drains to data memory over a req/gnt handshake.

It backpressures the ROB head when the store buffer cannot accept another store.

## Interface
- SB_DEPTH, 4, store-buffer entries; power of two, ≥2.
- clk_i  in  1  clock; all state updates on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- commit_valid_i  in  1  ROB head retires this cycle.
- commit_pc_i  in  32  PC of retiring instruction.
- commit_instr_i  in  32  instruction word; funct3 = bits [14:12].
- commit_rd_addr_i  in  5  destination register.
- commit_result_i  in  32  ALU result; for stores, the effective address.
- commit_write_enable_i  in  1  instruction writes rd.
- commit_store_to_mem_i  in  1  instruction is a store.
- commit_new_pc_i  in  32  branch target; for stores, the store data (rs2).
- commit_branch_taken_i  in  1  taken branch/jump.
- commit_ready_o  out  1  ROB may retire this cycle; ROB holds its head while low.
- rf_we_o, rf_waddr_o[4:0], rf_wdata_o[31:0]  out  register-file write port.
- redirect_valid_o  out  1  fetch redirect; redirect_pc_o  out  32  target.
- dmem_req_o  out  1  memory write request; dmem_gnt_i  in  1  grant.
- dmem_addr_o  out  32  word-aligned address.
- dmem_wdata_o  out  32  lane-aligned data.
- dmem_be_o  out  4  byte enables.
- sb_empty_o  out  1  no pending stores; used by load issue for ordering.
- misaligned_o  out  1  one-cycle pulse; a misaligned store was dropped.
- instret_o  out  64  retired-instruction count.

## Operation
**Register-file write.** Combinational, same cycle as commit.
- rf_we_o = commit_valid_i & commit_write_enable_i & (rd≠0).
- rf_waddr_o = rd; rf_wdata_o = result.

**Redirect.** Combinational.
- redirect_valid_o = commit_valid_i & commit_branch_taken_i.
- redirect_pc_o = commit_new_pc_i.
- A committed store and a redirect never coincide; stores have branch_taken=0.

**Store formatting.** Computed at commit. a = result[1:0]; d = new_pc.
- funct3 000 (SB): be = 4'b0001<<a; wdata = {4{d[7:0]}}.
- funct3 001 (SH): be = 4'b0011<<{a[1],0}; wdata = {2{d[15:0]}}; a[0]=1 is misaligned.
- funct3 010 (SW): be = 4'hF; wdata = d; a≠0 is misaligned.
- Other funct3 values: treated as SW.
- A misaligned store is not enqueued; misaligned_o pulses the following cycle (registered).
- addr = {result[31:2],2'b00}.

**Store buffer.**
- Circular FIFO of SB_DEPTH entries {addr, wdata, be}.
- Head/tail pointers wrap modulo SB_DEPTH; count register is 0..SB_DEPTH.
- commit_ready_o = (count < SB_DEPTH). This is conservative: a pop in the same cycle does not raise it.
- A store commit while commit_ready_o=0 is a protocol violation; it is asserted against and the entry is dropped.

**Drain FSM.**
- IDLE: dmem_req_o=0. Go to REQ when count>0.
- REQ: dmem_req_o=1, driving the head entry. Hold addr/wdata/be stable until dmem_gnt_i=1.
- On grant: pop. Stay in REQ if count after pop >0 (back-to-back), else go to IDLE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- sb_empty_o = (count==0) & (state==IDLE).

**Committed stores survive redirects.** Taken-branch commits and pipeline flushes never clear the store buffer.

**instret.** Increments by 1 on every commit_valid_i cycle, including dropped misaligned stores. Wraps at 2^64.

## Timing
- Reset values: state=IDLE, count=0, pointers=0, instret_o=0, dmem_req_o=0, misaligned_o=0, sb_empty_o=1, commit_ready_o=1. Data outputs are 0.
- Combinational outputs (rf_*, redirect_*) are 0 during reset when commit_valid_i=0.
- A store committed in cycle N is written at the end of N. dmem_req_o is high in N+1 at the earliest.
- With grant in the same cycle: one store per cycle sustained throughput.
- Reset asserted mid-request: dmem_req_o drops immediately (asynchronous) and the buffer contents are discarded.

## Configuration
- COMMIT_INSTRET_EN defined: 64-bit instret counter present; instret_o reflects the count.
- Not defined: counter removed; instret_o tied to 0.
- Everything else is identical in both builds.

## Test plan
- **Register write:** commit ADDI rd=5, result=0x1234 → rf_we_o=1, waddr=5, wdata=0x1234 same cycle. Repeat with rd=0 → rf_we_o=0.
- **Taken branch:** commit branch_taken=1, new_pc=0x80 → redirect_valid_o=1, redirect_pc_o=0x80 for exactly one cycle.
- **SB format:** store with result=0x1003, data=0xAB, funct3=000, dmem_gnt_i=1 → dmem_req_o next cycle, addr=0x1000, be=4'b1000, wdata=0xABABABAB; sb_empty_o=1 the cycle after grant.
- **Fill and drain:** gnt held low, commit 4 SW → commit_ready_o=0 after the 4th. Release gnt → 4 grants in 4 consecutive cycles in FIFO order; commit_ready_o=1 after the first pop.
- **Misaligned store:** SW to 0x2002 → nothing enqueued, misaligned_o pulses once, instret increments (COMMIT_INSTRET_EN build).
- **Reset during request:** assert rstn_i with dmem_req_o=1 and 2 entries pending → dmem_req_o=0 immediately, sb_empty_o=1, instret_o=0.
